// File: rtl/spi_bus_arbiter_if.sv
// Bus-side signals of the SPI bus arbiter.
// The arbiter connects through the slave modport (it serves requests);
// the requesters, or a bench standing in for them, use the master modport.
interface spi_bus_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] done;
    logic [N_REQ-1:0] grant;
    logic [IDW-1:0]   grant_id;
    logic             busy;
    logic             timeout;
    logic [IDW-1:0]   timeout_id;

    modport master (
        output req, done,
        input  grant, grant_id, busy, timeout, timeout_id
    );

    modport slave (
        input  req, done,
        output grant, grant_id, busy, timeout, timeout_id
    );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter sharing one SPI master among N_REQ requesters.
// A one-hot grant is held until the owner pulses done or drops req, then the
// bus idles for GAP_CYCLES cycles (CS deassert time) before the next grant.
// Optional hang watchdog: define ARB_TIMEOUT_EN to reclaim a grant held for
// TIMEOUT_CYCLES cycles; without it timeout/timeout_id are tied low.
module spi_bus_arbiter #(
    parameter int N_REQ          = 4,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 3000000
) (
    input  logic              clk,
    input  logic              rst,
    spi_bus_arbiter_if.slave  bus
);
    localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GCW-1:0] GAP_LOAD = GCW'(GAP_CYCLES - 1);

    // Reject configurations the counters cannot represent.
    if (N_REQ < 1 || N_REQ > 8 || GAP_CYCLES < 1 ||
        TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > (1 << 22)) begin : g_bad_params
        $error("spi_bus_arbiter: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t           state;
    logic [N_REQ-1:0] grant_q;
    logic [IDW-1:0]   grant_id_q;
    logic [IDW-1:0]   last_id;
    logic             busy_q;
    logic [GCW-1:0]   gap_cnt;

    logic             win_found;
    logic [IDW-1:0]   win_id;
    logic [IDW-1:0]   cand_id;
    logic             owner_release;

`ifdef ARB_TIMEOUT_EN
    localparam logic [21:0] HOLD_LAST = 22'(TIMEOUT_CYCLES - 1);

    logic [21:0]      hold_cnt;
    logic             timeout_q;
    logic [IDW-1:0]   timeout_id_q;
`endif

    // Round-robin pick: scan upward from the slot after the last owner, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand_id   = '0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand_id = IDW'((32'(last_id) + off) % N_REQ);
            if (!win_found && bus.req[cand_id]) begin
                win_found = 1'b1;
                win_id    = cand_id;
            end
        end
    end

    // Only the current owner's done/req can end a grant.
    always_comb begin
        owner_release = bus.done[grant_id_q] || !bus.req[grant_id_q];
    end

    // Arbitration FSM: IDLE -> GRANT -> RELEASE (gap) -> IDLE, all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            last_id      <= IDW'(N_REQ - 1);
            busy_q       <= 1'b0;
            gap_cnt      <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt     <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (win_found) begin
                        grant_q    <= N_REQ'(1) << win_id;
                        grant_id_q <= win_id;
                        last_id    <= win_id;
                        busy_q     <= 1'b1;
                        state      <= GRANT;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt   <= '0;
`endif
                    end
                end
                GRANT: begin
                    if (owner_release) begin
                        grant_q <= '0;
                        gap_cnt <= GAP_LOAD;
                        state   <= RELEASE;
`ifdef ARB_TIMEOUT_EN
                    // A normal release on the same edge wins over the watchdog.
                    end else if (hold_cnt == HOLD_LAST) begin
                        grant_q      <= '0;
                        gap_cnt      <= GAP_LOAD;
                        timeout_q    <= 1'b1;
                        timeout_id_q <= grant_id_q;
                        state        <= RELEASE;
                    end else begin
                        hold_cnt <= hold_cnt + 22'd1;
`endif
                    end
                end
                RELEASE: begin
                    if (gap_cnt == '0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - GCW'(1);
                    end
                end
                default: begin
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.grant    = grant_q;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = busy_q;

`ifdef ARB_TIMEOUT_EN
    assign bus.timeout    = timeout_q;
    assign bus.timeout_id = timeout_id_q;
`else
    assign bus.timeout    = 1'b0;
    assign bus.timeout_id = '0;
`endif

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Directed bench for spi_bus_arbiter (N_REQ=4, GAP_CYCLES=2, TIMEOUT_CYCLES=16).
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
// Build with ARB_TIMEOUT_EN defined to exercise the watchdog branch.
module tb_spi_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    spi_bus_arbiter_if #(.N_REQ(4)) bus_if ();

    spi_bus_arbiter #(
        .N_REQ(4),
        .GAP_CYCLES(2),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst = 1'b1;
        bus_if.req  = '0;
        bus_if.done = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_grant;
        int         exp_id;
        logic       seen_timeout;

        bus_if.req  = '0;
        bus_if.done = '0;

        // Reset values
        #12;
        check_eq("rst_grant", bus_if.grant, 4'b0000);
        check_eq("rst_busy", bus_if.busy, 1'b0);
        check_eq("rst_grant_id", bus_if.grant_id, 2'd0);
        check_eq("rst_timeout", bus_if.timeout, 1'b0);
        check_eq("rst_timeout_id", bus_if.timeout_id, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single requester, done 5 cycles after grant
        bus_if.req = 4'b0001;
        tick();
        check_eq("t1_grant", bus_if.grant, 4'b0001);
        check_eq("t1_grant_id", bus_if.grant_id, 2'd0);
        check_eq("t1_busy", bus_if.busy, 1'b1);
        repeat (4) tick();
        check_eq("t1_hold", bus_if.grant, 4'b0001);
        bus_if.done = 4'b0001;
        tick();
        bus_if.done = 4'b0000;
        bus_if.req  = 4'b0000;
        check_eq("t1_rel_grant", bus_if.grant, 4'b0000);
        check_eq("t1_rel_busy", bus_if.busy, 1'b1);
        tick();
        check_eq("t1_gap_busy", bus_if.busy, 1'b1);
        tick();
        check_eq("t1_idle_busy", bus_if.busy, 1'b0);
        tick();
        check_eq("t1_no_grant", bus_if.grant, 4'b0000);

        // All four requesting: order 0,1,2,3,0 with a 3-edge low gap
        do_reset();
        bus_if.req = 4'b1111;
        tick();
        for (int n = 0; n < 5; n++) begin
            exp_id    = n % 4;
            exp_grant = 4'b0001 << exp_id;
            check_eq($sformatf("t2_grant_%0d", n), bus_if.grant, exp_grant);
            check_eq($sformatf("t2_id_%0d", n), bus_if.grant_id, exp_id);
            tick();
            tick();
            check_eq($sformatf("t2_hold_%0d", n), bus_if.grant, exp_grant);
            bus_if.done = exp_grant;
            tick();
            bus_if.done = 4'b0000;
            check_eq($sformatf("t2_gap0_%0d", n), bus_if.grant, 4'b0000);
            tick();
            check_eq($sformatf("t2_gap1_%0d", n), bus_if.grant, 4'b0000);
            tick();
            check_eq($sformatf("t2_gap2_%0d", n), bus_if.grant, 4'b0000);
            tick();
        end

        // Non-owner done/req activity is ignored
        do_reset();
        bus_if.req = 4'b0100;
        tick();
        check_eq("t3_grant", bus_if.grant, 4'b0100);
        bus_if.req  = 4'b1100;
        bus_if.done = 4'b0010;
        tick();
        check_eq("t3_ign_a", bus_if.grant, 4'b0100);
        bus_if.req  = 4'b0100;
        bus_if.done = 4'b0000;
        tick();
        bus_if.req  = 4'b1100;
        bus_if.done = 4'b1010;
        tick();
        check_eq("t3_ign_b", bus_if.grant, 4'b0100);
        check_eq("t3_ign_id", bus_if.grant_id, 2'd2);
        bus_if.done = 4'b0100;
        tick();
        bus_if.done = 4'b0000;
        bus_if.req  = 4'b1000;
        check_eq("t3_rel", bus_if.grant, 4'b0000);
        repeat (3) tick();
        check_eq("t3_next_grant", bus_if.grant, 4'b1000);
        check_eq("t3_next_id", bus_if.grant_id, 2'd3);

        // Owner drops req and pulses done on the same edge
        do_reset();
        bus_if.req = 4'b0010;
        tick();
        check_eq("t4_grant", bus_if.grant, 4'b0010);
        tick();
        bus_if.req  = 4'b0000;
        bus_if.done = 4'b0010;
        tick();
        bus_if.done = 4'b0000;
        check_eq("t4_rel_grant", bus_if.grant, 4'b0000);
        check_eq("t4_rel_busy", bus_if.busy, 1'b1);
        tick();
        check_eq("t4_gap_busy", bus_if.busy, 1'b1);
        tick();
        check_eq("t4_idle_busy", bus_if.busy, 1'b0);
        bus_if.done = 4'b0001;
        tick();
        bus_if.done = 4'b0000;
        check_eq("t4_idle_done_grant", bus_if.grant, 4'b0000);
        check_eq("t4_idle_done_busy", bus_if.busy, 1'b0);
        tick();
        check_eq("t4_quiet_busy", bus_if.busy, 1'b0);

        // Asynchronous reset in the middle of a grant
        do_reset();
        bus_if.req = 4'b1111;
        tick();
        bus_if.done = 4'b0001;
        tick();
        bus_if.done = 4'b0000;
        repeat (3) tick();
        check_eq("t5_pre_grant", bus_if.grant, 4'b0010);
        #3;
        rst = 1'b1;
        #1;
        check_eq("t5_async_grant", bus_if.grant, 4'b0000);
        check_eq("t5_async_busy", bus_if.busy, 1'b0);
        check_eq("t5_async_id", bus_if.grant_id, 2'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        check_eq("t5_first_grant", bus_if.grant, 4'b0001);

        // Owner 3 never sends done
        do_reset();
        bus_if.req = 4'b1000;
        tick();
        check_eq("t6_grant", bus_if.grant, 4'b1000);
        bus_if.req = 4'b1001;
`ifdef ARB_TIMEOUT_EN
        repeat (15) tick();
        check_eq("t6_held16", bus_if.grant, 4'b1000);
        check_eq("t6_no_to_yet", bus_if.timeout, 1'b0);
        tick();
        check_eq("t6_to_grant", bus_if.grant, 4'b0000);
        check_eq("t6_to_pulse", bus_if.timeout, 1'b1);
        check_eq("t6_to_id", bus_if.timeout_id, 2'd3);
        check_eq("t6_to_busy", bus_if.busy, 1'b1);
        tick();
        check_eq("t6_to_one_cycle", bus_if.timeout, 1'b0);
        check_eq("t6_to_id_kept", bus_if.timeout_id, 2'd3);
        tick();
        check_eq("t6_idle_busy", bus_if.busy, 1'b0);
        tick();
        check_eq("t6_rr_grant", bus_if.grant, 4'b0001);
`else
        seen_timeout = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (bus_if.timeout !== 1'b0) seen_timeout = 1'b1;
        end
        check_eq("t6_persist_grant", bus_if.grant, 4'b1000);
        check_eq("t6_persist_to", seen_timeout, 1'b0);
        check_eq("t6_to_id_zero", bus_if.timeout_id, 2'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
